// File: rtl/mem_stage_dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory unit: FSM encoding,
// latency bound, index-width derivation and memory-op decode.
package mem_stage_dmem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam int unsigned LATENCY_MAX = 7;

   // RAM is word addressed, so the index width equals log2 of the depth.
   function automatic int unsigned idx_width(input int unsigned depth_log2);
      return depth_log2;
   endfunction

   function automatic logic is_mem_op(input logic mem_wr, input logic mem_to_reg);
      return mem_wr | mem_to_reg;
   endfunction

endpackage

// File: rtl/mem_stage_dmem_if.sv
// EX/MEM-side bundle into the data-memory unit and its outputs toward MEM/WR.
interface mem_stage_dmem_if;

   logic [31:0] MEM_ALUout;
   logic [31:0] MEM_Busb;
   logic [4:0]  MEM_Rw;
   logic        MEM_Overflow;
   logic        MEM_MemWr;
   logic        MEM_MemtoReg;
   logic        MEM_RegWr;

   logic [31:0] MEM_Dout;
   logic [31:0] Out_ALUout;
   logic [4:0]  Out_Rw;
   logic        Out_Overflow;
   logic        Out_MemtoReg;
   logic        Out_RegWr;
   logic        Stall;
   logic        AddrErr;

   modport master (
      output MEM_ALUout, MEM_Busb, MEM_Rw, MEM_Overflow, MEM_MemWr, MEM_MemtoReg, MEM_RegWr,
      input  MEM_Dout, Out_ALUout, Out_Rw, Out_Overflow, Out_MemtoReg, Out_RegWr, Stall, AddrErr
   );

   modport slave (
      input  MEM_ALUout, MEM_Busb, MEM_Rw, MEM_Overflow, MEM_MemWr, MEM_MemtoReg, MEM_RegWr,
      output MEM_Dout, Out_ALUout, Out_Rw, Out_Overflow, Out_MemtoReg, Out_RegWr, Stall, AddrErr
   );

endinterface

// File: rtl/mem_stage_dmem_array.sv
// Word-organised data RAM: combinational read, single write port on negedge.
module dmem_array #(
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] idx_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [2**DEPTH_LOG2];

   always_ff @(negedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data-memory unit: multi-cycle lw/sw with upstream stall,
// bubble injection toward MEM/WR and misalignment detection.
module mem_stage_dmem
   import mem_stage_dmem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 3
) (
   input  logic              Clk,
   input  logic              Clrn,
   mem_stage_dmem_if.slave   bus
);

   localparam int unsigned IW   = idx_width(DEPTH_LOG2);
   localparam logic [2:0]  LAST = 3'(LATENCY - 1);

   state_e         state_q, state_d;
   logic [2:0]     cnt_q, cnt_d;
   logic           mem_op, aligned, both_set, store_en;
   logic           stall, regwr, addr_err, we;
   logic [IW-1:0]  idx;

   assign mem_op   = is_mem_op(bus.MEM_MemWr, bus.MEM_MemtoReg);
   assign aligned  = (bus.MEM_ALUout[1:0] == 2'b00);
   assign both_set = bus.MEM_MemWr & bus.MEM_MemtoReg;
   assign store_en = bus.MEM_MemWr & ~bus.MEM_Overflow;
   assign idx      = bus.MEM_ALUout[IW+1:2];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall    = 1'b0;
      regwr    = bus.MEM_RegWr & ~both_set;
      addr_err = 1'b0;
      we       = 1'b0;
      if (!Clrn) begin
         regwr = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (mem_op) begin
                  if (!aligned) begin
                     addr_err = 1'b1;
                     regwr    = 1'b0;
                  end else if (LATENCY == 1) begin
                     we = store_en;
                  end else begin
                     stall   = 1'b1;
                     regwr   = 1'b0;
                     state_d = BUSY;
                     cnt_d   = 3'd1;
                  end
               end
            end
            BUSY: begin
               // cnt only advances below LAST, so it saturates instead of wrapping
               if (cnt_q < LAST) begin
                  stall = 1'b1;
                  regwr = 1'b0;
                  cnt_d = cnt_q + 3'd1;
               end else begin
                  we      = store_en;
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(negedge Clk) begin
      if (!Clrn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   dmem_array #(
      .DEPTH_LOG2(IW)
   ) u_array (
      .clk_i   (Clk),
      .we_i    (we),
      .idx_i   (idx),
      .wdata_i (bus.MEM_Busb),
      .rdata_o (bus.MEM_Dout)
   );

   assign bus.Out_ALUout   = bus.MEM_ALUout;
   assign bus.Out_Rw       = bus.MEM_Rw;
   assign bus.Out_Overflow = bus.MEM_Overflow;
   assign bus.Out_MemtoReg = bus.MEM_MemtoReg;
   assign bus.Out_RegWr    = regwr;
   assign bus.Stall        = stall;
   assign bus.AddrErr      = addr_err;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed self-checking bench for mem_stage_dmem with LATENCY=3.
module tb_mem_stage_dmem;

   logic Clk;
   logic Clrn;
   int   checks;
   int   errors;

   mem_stage_dmem_if bus ();

   mem_stage_dmem #(
      .DEPTH_LOG2(10),
      .LATENCY(3)
   ) dut (
      .Clk  (Clk),
      .Clrn (Clrn),
      .bus  (bus)
   );

   initial Clk = 1'b1;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the negedge that closes the previous cycle.
   task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rw,
                        input logic ovf, input logic memwr, input logic memtoreg, input logic regwr);
      @(negedge Clk);
      #1;
      bus.MEM_ALUout   = addr;
      bus.MEM_Busb     = data;
      bus.MEM_Rw       = rw;
      bus.MEM_Overflow = ovf;
      bus.MEM_MemWr    = memwr;
      bus.MEM_MemtoReg = memtoreg;
      bus.MEM_RegWr    = regwr;
   endtask

   // Advance to the mid-cycle sampling point (posedge).
   task automatic sample;
      @(posedge Clk);
   endtask

   // Runs one full op with the inputs held; checks Stall/Out_RegWr each cycle.
   task automatic run_op(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic memwr, input logic memtoreg, input logic regwr, input logic ovf,
                         input logic final_regwr);
      drive(addr, data, 5'd7, ovf, memwr, memtoreg, regwr);
      sample;
      chk({tag, "_stall_c1"}, 32'(bus.Stall), 32'd1);
      chk({tag, "_regwr_c1"}, 32'(bus.Out_RegWr), 32'd0);
      @(negedge Clk);
      sample;
      chk({tag, "_stall_c2"}, 32'(bus.Stall), 32'd1);
      chk({tag, "_regwr_c2"}, 32'(bus.Out_RegWr), 32'd0);
      @(negedge Clk);
      sample;
      chk({tag, "_stall_c3"}, 32'(bus.Stall), 32'd0);
      chk({tag, "_regwr_c3"}, 32'(bus.Out_RegWr), 32'(final_regwr));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      Clrn = 1'b0;
      bus.MEM_ALUout   = 32'h0;
      bus.MEM_Busb     = 32'h0;
      bus.MEM_Rw       = 5'd0;
      bus.MEM_Overflow = 1'b0;
      bus.MEM_MemWr    = 1'b0;
      bus.MEM_MemtoReg = 1'b1;
      bus.MEM_RegWr    = 1'b1;

      // Reset: outputs held quiet even with a load presented
      @(negedge Clk);
      sample;
      chk("rst_stall", 32'(bus.Stall), 32'd0);
      chk("rst_regwr", 32'(bus.Out_RegWr), 32'd0);
      chk("rst_addrerr", 32'(bus.AddrErr), 32'd0);
      @(negedge Clk);
      #1;
      Clrn = 1'b1;
      bus.MEM_MemtoReg = 1'b0;
      bus.MEM_RegWr    = 1'b0;

      // Known RAM contents for later reads
      run_op("init0", 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("init1", 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("init2", 32'h14, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // 1: sw 0x10 DEADBEEF; RAM unchanged until the final edge
      run_op("sw", 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sw_dout_before_write", bus.MEM_Dout, 32'h0);
      drive(32'h10, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample;
      chk("sw_dout_after_write", bus.MEM_Dout, 32'hDEADBEEF);
      chk("sw_idle_stall", 32'(bus.Stall), 32'd0);

      // 2 + 3: back-to-back loads, no gap cycle
      run_op("lw10", 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("lw10_dout", bus.MEM_Dout, 32'hDEADBEEF);
      chk("lw10_rw", 32'(bus.Out_Rw), 32'd7);
      chk("lw10_memtoreg", 32'(bus.Out_MemtoReg), 32'd1);
      run_op("lw14", 32'h14, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("lw14_dout", bus.MEM_Dout, 32'hCAFEF00D);

      // 4: non-memory ALU op passes straight through
      drive(32'h55, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      sample;
      chk("alu_stall", 32'(bus.Stall), 32'd0);
      chk("alu_aluout", bus.Out_ALUout, 32'h55);
      chk("alu_regwr", 32'(bus.Out_RegWr), 32'd1);
      chk("alu_rw", 32'(bus.Out_Rw), 32'd3);

      // 5: misaligned load
      drive(32'h13, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1);
      sample;
      chk("mis_addrerr", 32'(bus.AddrErr), 32'd1);
      chk("mis_stall", 32'(bus.Stall), 32'd0);
      chk("mis_regwr", 32'(bus.Out_RegWr), 32'd0);
      drive(32'h40, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
      sample;
      chk("mis_next_addrerr", 32'(bus.AddrErr), 32'd0);
      chk("mis_next_stall", 32'(bus.Stall), 32'd0);
      chk("mis_next_regwr", 32'(bus.Out_RegWr), 32'd1);

      // 6a: reset during cycle 2 of sw 0x20 abandons the write
      drive(32'h20, 32'h1234, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      sample;
      chk("rstmid_stall_c1", 32'(bus.Stall), 32'd1);
      @(negedge Clk);
      #1;
      Clrn = 1'b0;
      sample;
      chk("rstmid_stall_c2", 32'(bus.Stall), 32'd0);
      chk("rstmid_regwr_c2", 32'(bus.Out_RegWr), 32'd0);
      chk("rstmid_addrerr_c2", 32'(bus.AddrErr), 32'd0);
      @(negedge Clk);
      #1;
      Clrn = 1'b1;
      bus.MEM_MemWr = 1'b0;
      sample;
      chk("rstmid_stall_after", 32'(bus.Stall), 32'd0);
      chk("rstmid_ram8", bus.MEM_Dout, 32'h0);
      @(negedge Clk);
      sample;
      chk("rstmid_ram8_later", bus.MEM_Dout, 32'h0);

      // 6b: overflowing store keeps normal timing but never writes
      run_op("ovf", 32'h10, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ovf_passthru", 32'(bus.Out_Overflow), 32'd1);
      drive(32'h10, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample;
      chk("ovf_ram4", bus.MEM_Dout, 32'hDEADBEEF);

      // Both MemWr and MemtoReg: store, Out_RegWr forced low
      run_op("both", 32'h14, 32'h00000077, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(32'h14, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample;
      chk("both_ram5", bus.MEM_Dout, 32'h00000077);

      // Upper address bits are ignored: 0x1010 aliases word 4
      drive(32'h1010, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      sample;
      chk("wrap_ram4", bus.MEM_Dout, 32'hDEADBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_dmem.md
Name: mem_stage_dmem

Overview:
- MEM-stage data-memory unit of the 5-stage pipeline. It sits directly upstream of the MEM/WR pipeline register and feeds it.
- Services lw/sw against a word-addressed data RAM with configurable access latency.
- Raises Stall to freeze the PC, IF/ID, ID/EX and EX/MEM registers while an access is in flight.
- Injects a bubble (RegWr=0) toward MEM/WR on every stalled cycle.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words).
- LATENCY, 3, cycles a memory op occupies MEM; legal range 1..7.

Ports:
- Clk  in  1  clock; all state updates on negedge Clk, same edge as the pipeline registers.
- Clrn  in  1  synchronous active-low reset, sampled on that edge.
- MEM_ALUout  in  32  ALU result / byte address, from EX/MEM.
- MEM_Busb  in  32  store data, from EX/MEM.
- MEM_Rw  in  5  destination register.
- MEM_Overflow  in  1  overflow flag.
- MEM_MemWr  in  1  store.
- MEM_MemtoReg  in  1  load.
- MEM_RegWr  in  1  register write enable.
- MEM_Dout  out  32  load data to MEM/WR.
- Out_ALUout  out  32  pass-through of MEM_ALUout.
- Out_Rw  out  5  pass-through of MEM_Rw.
- Out_Overflow  out  1  pass-through of MEM_Overflow.
- Out_MemtoReg  out  1  pass-through of MEM_MemtoReg.
- Out_RegWr  out  1  gated register write enable (bubble when 0).
- Stall  out  1  freeze upstream stages.
- AddrErr  out  1  misaligned memory op in MEM this cycle.

Behaviour:
- Clock and reset: one clock, Clk; reset Clrn is synchronous and active-low.
- Mem op: MemWr | MemtoReg. If both are set, the op is treated as a store and Out_RegWr is forced 0.
- Word index: ALUout[DEPTH_LOG2+1:2]; upper address bits are ignored, so addresses wrap.
- Aligned: ALUout[1:0]==0.
- State: FSM {IDLE, BUSY} plus a 3-bit cycle counter cnt.
- Reset: Clrn low at an edge sets state=IDLE and cnt=0. RAM contents are not cleared.
  - While Clrn is low, Stall=0, Out_RegWr=0 and AddrErr=0.
- IDLE, no mem op: Stall=0; all fields pass through combinationally; Out_RegWr=MEM_RegWr.
- IDLE, aligned mem op:
  - LATENCY==1: Stall=0; a store writes at the closing edge; the load is served this cycle; state unchanged.
  - LATENCY>1: Stall=1, Out_RegWr=0; next state BUSY, cnt<=1.
- BUSY, cnt<LATENCY-1: Stall=1, Out_RegWr=0, cnt++.
- BUSY, cnt==LATENCY-1 (final cycle):
  - Stall=0 and Out_RegWr=MEM_RegWr.
  - A store writes RAM at this cycle's closing edge.
  - Next state IDLE, cnt<=0.
- Access timing:
  - Total MEM occupancy is exactly LATENCY cycles, with Stall high for the first LATENCY-1.
  - Each store writes exactly once.
- Load data: MEM_Dout = RAM[index], read combinationally. It is valid in the final cycle; the address is stable because EX/MEM is frozen.
- Back-to-back ops: a new op entering MEM on the cycle after a final cycle starts immediately, with no gap cycle.
- Misaligned mem op:
  - AddrErr=1 for one cycle; Stall=0; no RAM access.
  - Out_RegWr=0; the FSM stays IDLE.
- Overflow: MEM_Overflow=1 suppresses the store write. Timing and Stall behave as for a normal store.
- Reset mid-access: the access is abandoned and the pending store is never written. The next edge with Clrn high starts from IDLE.
- Reference widths: MEM_Dout 32 bits; cnt saturates at LATENCY-1 and never wraps.

Decomposition:
- Shared package holds:
  - FSM state encoding {IDLE, BUSY}.
  - LATENCY_MAX=7.
  - Word-index width derivation from DEPTH_LOG2.
  - An is_mem_op decode helper.
- One sub-module, dmem_array: 2^DEPTH_LOG2 x 32 storage, combinational read, negedge write port (we, index, data).
- The FSM, gating and pass-through logic stay in the top-level module.

Test Plan:
1. LATENCY=3. sw addr 0x10, Busb 0xDEADBEEF -> Stall 1,1,0 over 3 cycles; RAM[4] written once, at the end of cycle 3; Out_RegWr 0 throughout.
2. LATENCY=3. lw addr 0x10 after (1) -> MEM_Dout=0xDEADBEEF in cycle 3; Out_RegWr=1 only in cycle 3; Stall pattern 1,1,0.
3. Back-to-back lw 0x10, lw 0x14 -> Stall pattern 1,1,0,1,1,0 with no gap; two Out_RegWr pulses, in cycles 3 and 6.
4. Non-mem ALU op, RegWr=1, ALUout 0x55 -> Stall=0; Out_ALUout=0x55 and Out_RegWr=1 in the same cycle.
5. lw addr 0x13 -> AddrErr=1 for one cycle, Stall=0, Out_RegWr=0, FSM stays IDLE.
6. sw 0x20, data 0x1234, with Clrn low during cycle 2 -> RAM[8] keeps its prior 0; Stall=0 while in reset. Also sw with Overflow=1 -> no write.
